// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral endpoint.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

    // SPI modes encoded as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    localparam int SYNC_DEPTH = 2;

    // Modes 0 and 3 capture MOSI on the rising SCLK edge, modes 1 and 2 on the falling edge
    function automatic logic sample_on_rise(input logic [1:0] mode);
        return (mode == MODE0) || (mode == MODE3);
    endfunction

endpackage

// File: rtl/spi_input_sync.sv
// Synchroniser for the asynchronous SPI pins {mosi, cs_n, sclk} plus SCLK edge pulses.
module spi_input_sync
    import spi_pkg::*;
#(
    parameter logic [2:0] IDLE_VAL = 3'b010
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [2:0] pin_async,
    output logic [2:0] pin_sync,
    output logic       sclk_rise,
    output logic       sclk_fall
);

    logic [2:0] chain [SYNC_DEPTH];
    logic       sclk_prev;

    // Reset to the idle pin levels so a reset never fakes a CS_n fall or SCLK edge
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                chain[i] <= IDLE_VAL;
            end
            sclk_prev <= IDLE_VAL[0];
        end else begin
            chain[0] <= pin_async;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                chain[i] <= chain[i-1];
            end
            sclk_prev <= chain[SYNC_DEPTH-1][0];
        end
    end

    assign pin_sync  = chain[SYNC_DEPTH-1];
    assign sclk_rise = pin_sync[0] & ~sclk_prev;
    assign sclk_fall = ~pin_sync[0] & sclk_prev;

endmodule

// File: rtl/spi_peripheral.sv
// SPI target endpoint with valid/ready TX and RX word interfaces.
// Optional sticky overrun/underrun flags when SPI_PERIPHERAL_STATUS_EN is defined.
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter bit               CPOL    = 1'b0,
    parameter bit               CPHA    = 1'b0,
    parameter logic [WIDTH-1:0] TX_IDLE = '1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_sclk,
    input  logic             i_cs_n,
    input  logic             i_mosi,
    output logic             o_miso,
    output logic             o_miso_oe,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
`ifdef SPI_PERIPHERAL_STATUS_EN
    output logic             o_rx_overrun,
    output logic             o_tx_underrun,
    input  logic             i_status_clr,
`endif
    output logic             o_busy
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [1:0]       MODE     = {CPOL, CPHA};

    logic [2:0]       pin_sync;
    logic             sclk_rise;
    logic             sclk_fall;
    logic             cs_n_s;
    logic             mosi_s;
    logic             sample_evt;
    logic             shift_evt;

    spi_state_e       state;
    spi_state_e       next_state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_rx;
    logic [WIDTH-1:0] shift_tx;
    logic [WIDTH-1:0] tx_buf;
    logic [WIDTH-1:0] tx_word;
    logic             tx_full;
    logic             miso_bit;
    logic             load_now;
    logic             frame_done;

    spi_input_sync #(
        .IDLE_VAL ({1'b0, 1'b1, CPOL})
    ) u_sync (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .pin_async ({i_mosi, i_cs_n, i_sclk}),
        .pin_sync  (pin_sync),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign cs_n_s     = pin_sync[1];
    assign mosi_s     = pin_sync[2];
    assign sample_evt = sample_on_rise(MODE) ? sclk_rise : sclk_fall;
    assign shift_evt  = sample_on_rise(MODE) ? sclk_fall : sclk_rise;

    assign load_now   = (state == LOAD);
    assign frame_done = (state == SHIFT) && (bit_cnt == CNT_FULL) && !cs_n_s;
    assign tx_word    = tx_full ? tx_buf : TX_IDLE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!cs_n_s) next_state = LOAD;
            LOAD:    next_state = SHIFT;
            SHIFT:   if (bit_cnt == CNT_FULL) next_state = LOAD;
            default: next_state = IDLE;
        endcase
        if (cs_n_s) begin
            next_state = IDLE;
        end
    end

    // With CPHA=0 the trailing edge of the previous frame's last bit arrives after LOAD;
    // it is ignored while bit_cnt is 0 so the freshly loaded MSB stays on MISO.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bit_cnt  <= '0;
            shift_rx <= '0;
            shift_tx <= '0;
            miso_bit <= 1'b0;
        end else if (cs_n_s) begin
            bit_cnt  <= '0;
            miso_bit <= 1'b0;
        end else if (load_now) begin
            bit_cnt <= '0;
            if (CPHA) begin
                shift_tx <= tx_word;
            end else begin
                miso_bit <= tx_word[WIDTH-1];
                shift_tx <= tx_word << 1;
            end
        end else if (state == SHIFT) begin
            if (frame_done) begin
                bit_cnt <= '0;
            end else if (sample_evt) begin
                shift_rx <= {shift_rx[WIDTH-2:0], mosi_s};
                bit_cnt  <= bit_cnt + 1'b1;
            end
            if (shift_evt && (CPHA || (bit_cnt != '0))) begin
                miso_bit <= shift_tx[WIDTH-1];
                shift_tx <= shift_tx << 1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_full <= 1'b0;
            tx_buf  <= '0;
        end else begin
            if (load_now) begin
                tx_full <= 1'b0;
            end
            if (i_tx_valid && !tx_full) begin
                tx_buf  <= i_tx_data;
                tx_full <= 1'b1;
            end
        end
    end

    // A completing frame overrides a same-cycle consume
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rx_data  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            if (i_rx_ready) begin
                o_rx_valid <= 1'b0;
            end
            if (frame_done) begin
                o_rx_data  <= shift_rx;
                o_rx_valid <= 1'b1;
            end
        end
    end

`ifdef SPI_PERIPHERAL_STATUS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rx_overrun  <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            if (i_status_clr) begin
                o_rx_overrun  <= 1'b0;
                o_tx_underrun <= 1'b0;
            end
            if (frame_done && o_rx_valid && !i_rx_ready) begin
                o_rx_overrun <= 1'b1;
            end
            if (load_now && !tx_full) begin
                o_tx_underrun <= 1'b1;
            end
        end
    end
`endif

    assign o_tx_ready = !tx_full;
    assign o_busy     = (bit_cnt != '0);
    assign o_miso_oe  = (state != IDLE);
    assign o_miso     = o_miso_oe & miso_bit;

endmodule

// File: tb/tb_spi_peripheral.sv
// Self-checking bench for spi_peripheral: mode 0 against a word-level model, mode 3 directed.
module tb_spi_peripheral;

    localparam int HALF = 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       sclk;
    logic       mosi;
    logic       cs0_n;
    logic       cs3_n;
    logic [7:0] tx_data;
    logic       tx_valid0;
    logic       tx_valid3;
    logic       rx_ready0;
    logic       rx_ready3;

    logic       miso0, miso_oe0, tx_ready0, rx_valid0, busy0;
    logic [7:0] rx_data0;
    logic       miso3, miso_oe3, tx_ready3, rx_valid3, busy3;
    logic [7:0] rx_data3;
`ifdef SPI_PERIPHERAL_STATUS_EN
    logic       status_clr;
    logic       over0, under0, over3, under3;
`endif

    always #5 i_clk = ~i_clk;

    spi_peripheral #(.WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .TX_IDLE(8'hFF)) dut0 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sclk        (sclk),
        .i_cs_n        (cs0_n),
        .i_mosi        (mosi),
        .o_miso        (miso0),
        .o_miso_oe     (miso_oe0),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid0),
        .o_tx_ready    (tx_ready0),
        .o_rx_data     (rx_data0),
        .o_rx_valid    (rx_valid0),
        .i_rx_ready    (rx_ready0),
`ifdef SPI_PERIPHERAL_STATUS_EN
        .o_rx_overrun  (over0),
        .o_tx_underrun (under0),
        .i_status_clr  (status_clr),
`endif
        .o_busy        (busy0)
    );

    spi_peripheral #(.WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .TX_IDLE(8'hFF)) dut3 (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_sclk        (sclk),
        .i_cs_n        (cs3_n),
        .i_mosi        (mosi),
        .o_miso        (miso3),
        .o_miso_oe     (miso_oe3),
        .i_tx_data     (tx_data),
        .i_tx_valid    (tx_valid3),
        .o_tx_ready    (tx_ready3),
        .o_rx_data     (rx_data3),
        .o_rx_valid    (rx_valid3),
        .i_rx_ready    (rx_ready3),
`ifdef SPI_PERIPHERAL_STATUS_EN
        .o_rx_overrun  (over3),
        .o_tx_underrun (under3),
        .i_status_clr  (status_clr),
`endif
        .o_busy        (busy3)
    );

    int         checks = 0;
    int         fails = 0;
    bit         settled = 1'b0;
    logic       exp_tx_full;
    logic [7:0] exp_tx_buf;
    logic       exp_rx_valid;
    logic [7:0] exp_rx_data;
    logic       exp_over;
    logic       exp_under;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        exp_tx_full  = 1'b0;
        exp_tx_buf   = 8'h00;
        exp_rx_valid = 1'b0;
        exp_rx_data  = 8'h00;
        exp_over     = 1'b0;
        exp_under    = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic write_tx(input int sel, input logic [7:0] d);
        tx_data = d;
        if (sel == 0) tx_valid0 = 1'b1;
        else          tx_valid3 = 1'b1;
        @(posedge i_clk);
        #1;
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
        if (sel == 0 && !exp_tx_full) begin
            exp_tx_full = 1'b1;
            exp_tx_buf  = d;
        end
    endtask

    task automatic consume_rx();
        rx_ready0 = 1'b1;
        @(posedge i_clk);
        #1;
        rx_ready0    = 1'b0;
        exp_rx_valid = 1'b0;
    endtask

    task automatic status_clear();
`ifdef SPI_PERIPHERAL_STATUS_EN
        status_clr = 1'b1;
        @(posedge i_clk);
        #1;
        status_clr = 1'b0;
        exp_over   = 1'b0;
        exp_under  = 1'b0;
`endif
    endtask

    task automatic cs_select(input int sel);
        if (sel == 0) begin
            settled = 1'b0;
            cs0_n   = 1'b0;
        end else begin
            cs3_n = 1'b0;
        end
        wait_cycles(8);
    endtask

    task automatic cs_release(input int sel);
        if (sel == 0) cs0_n = 1'b1;
        else          cs3_n = 1'b1;
        wait_cycles(6);
        if (sel == 0) settled = 1'b1;
    endtask

    // Acts as the SPI controller for nbits bits; captures MISO on the controller's sample edge
    task automatic applyStimulus(input int sel, input logic [7:0] word, input int nbits,
                                 input bit mid_tx, input logic [7:0] mid_word,
                                 output logic [7:0] miso_word);
        logic cpol;
        logic cpha;
        int   idx;
        bit   seen;
        cpol      = (sel == 3);
        cpha      = (sel == 3);
        miso_word = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            idx = 7 - k;
            if (!cpha) begin
                mosi = word[idx];
                wait_cycles(HALF);
                miso_word[idx] = (sel == 0) ? miso0 : miso3;
                sclk = ~cpol;
                if (sel == 0 && k == 7) begin
                    seen = 1'b0;
                    for (int c = 0; c < 5; c++) begin
                        @(negedge i_clk);
                        if (rx_valid0 && rx_data0 == word) seen = 1'b1;
                    end
                    checkOutput("rx_latency", seen, 1'b1);
                    @(posedge i_clk);
                    #1;
                end else begin
                    wait_cycles(HALF);
                end
                if (mid_tx && k == 3) write_tx(sel, mid_word);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[idx];
                wait_cycles(HALF);
                miso_word[idx] = (sel == 0) ? miso0 : miso3;
                sclk = cpol;
                wait_cycles(HALF);
                if (mid_tx && k == 3) write_tx(sel, mid_word);
            end
        end
    endtask

    // One mode-0 frame on dut0 with the word-level model updated around it
    task automatic frame0(input logic [7:0] word, input int nbits, input bit mid_tx,
                          input logic [7:0] mid_word, output logic [7:0] got);
        logic [7:0] exp_miso;
        logic [7:0] mask;
        exp_miso = exp_tx_full ? exp_tx_buf : 8'hFF;
        if (!exp_tx_full) exp_under = 1'b1;
        exp_tx_full = 1'b0;
        applyStimulus(0, word, nbits, mid_tx, mid_word, got);
        mask = 8'hFF << (8 - nbits);
        checkOutput("miso_word", got & mask, exp_miso & mask);
        if (nbits == 8) begin
            if (exp_rx_valid) exp_over = 1'b1;
            exp_rx_valid = 1'b1;
            exp_rx_data  = word;
        end
    endtask

    always @(negedge i_clk) begin
        if (settled) begin
            checkOutput("rx_valid", rx_valid0, exp_rx_valid);
            checkOutput("rx_data", rx_data0, exp_rx_data);
            checkOutput("tx_ready", tx_ready0, !exp_tx_full);
            checkOutput("busy_idle", busy0, 1'b0);
            checkOutput("miso_oe_idle", miso_oe0, 1'b0);
            checkOutput("miso_idle", miso0, 1'b0);
`ifdef SPI_PERIPHERAL_STATUS_EN
            checkOutput("rx_overrun", over0, exp_over);
            checkOutput("tx_underrun", under0, exp_under);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        logic [7:0] got;
        int         nfr;
        int         nb;
        i_rst     = 1'b1;
        sclk      = 1'b0;
        mosi      = 1'b0;
        cs0_n     = 1'b1;
        cs3_n     = 1'b1;
        tx_data   = 8'h00;
        tx_valid0 = 1'b0;
        tx_valid3 = 1'b0;
        rx_ready0 = 1'b0;
        rx_ready3 = 1'b0;
`ifdef SPI_PERIPHERAL_STATUS_EN
        status_clr = 1'b0;
`endif
        model_reset();
        wait_cycles(3);
        @(negedge i_clk);
        checkOutput("rst_tx_ready0", tx_ready0, 1'b1);
        checkOutput("rst_rx_valid0", rx_valid0, 1'b0);
        checkOutput("rst_miso0", miso0, 1'b0);
        checkOutput("rst_tx_ready3", tx_ready3, 1'b1);
        checkOutput("rst_miso_oe3", miso_oe3, 1'b0);
        i_rst = 1'b0;
        wait_cycles(2);
        settled = 1'b1;
        $display("[TB] mode 0 single frame");
        write_tx(0, 8'hA5);
        cs_select(0);
        frame0(8'h3C, 8, 1'b0, 8'h00, got);
        checkOutput("t1_miso", got, 8'hA5);
        cs_release(0);
        checkOutput("t1_rx_data", rx_data0, 8'h3C);
        consume_rx();

        $display("[TB] back-to-back frames");
        write_tx(0, 8'hC3);
        cs_select(0);
        frame0(8'h12, 8, 1'b1, 8'h7E, got);
        checkOutput("t2_miso1", got, 8'hC3);
        checkOutput("t2_rx1", rx_data0, 8'h12);
        checkOutput("t2_valid1", rx_valid0, 1'b1);
        consume_rx();
        frame0(8'h34, 8, 1'b0, 8'h00, got);
        checkOutput("t2_miso2", got, 8'h7E);
        cs_release(0);
        checkOutput("t2_rx2", rx_data0, 8'h34);
        consume_rx();

        $display("[TB] aborted frame");
        cs_select(0);
        frame0(8'hF0, 5, 1'b0, 8'h00, got);
        checkOutput("t3_busy_mid", busy0, 1'b1);
        cs_release(0);
        checkOutput("t3_no_valid", rx_valid0, 1'b0);
        cs_select(0);
        frame0(8'h81, 8, 1'b0, 8'h00, got);
        cs_release(0);
        checkOutput("t3_rx", rx_data0, 8'h81);
        consume_rx();
        status_clear();

        $display("[TB] underrun");
        cs_select(0);
        frame0(8'h55, 8, 1'b0, 8'h00, got);
        checkOutput("t4_idle_word", got, 8'hFF);
        cs_release(0);
`ifdef SPI_PERIPHERAL_STATUS_EN
        checkOutput("t4_underrun", under0, 1'b1);
`endif
        status_clear();
        consume_rx();

        $display("[TB] overrun");
        cs_select(0);
        frame0(8'h01, 8, 1'b0, 8'h00, got);
        frame0(8'h02, 8, 1'b0, 8'h00, got);
        cs_release(0);
        checkOutput("t5_rx", rx_data0, 8'h02);
        checkOutput("t5_valid", rx_valid0, 1'b1);
`ifdef SPI_PERIPHERAL_STATUS_EN
        checkOutput("t5_overrun", over0, 1'b1);
`endif
        status_clear();
        consume_rx();

        $display("[TB] randomized traffic");
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(1, 0) == 1) write_tx(0, 8'($urandom));
            if ($urandom_range(1, 0) == 1) consume_rx();
            if ($urandom_range(3, 0) == 0) status_clear();
            nfr = $urandom_range(2, 1);
            cs_select(0);
            for (int f = 0; f < nfr; f++) begin
                nb = 8;
                if (f == nfr - 1 && $urandom_range(3, 0) == 0) nb = $urandom_range(7, 1);
                frame0(8'($urandom), nb, 1'b0, 8'h00, got);
            end
            cs_release(0);
        end

        $display("[TB] mode 3 and reset mid-frame");
        sclk = 1'b1;
        wait_cycles(4);
        write_tx(3, 8'h39);
        cs_select(3);
        applyStimulus(3, 8'hC6, 8, 1'b0, 8'h00, got);
        cs_release(3);
        checkOutput("t6_miso", got, 8'h39);
        checkOutput("t6_rx", rx_data3, 8'hC6);
        checkOutput("t6_valid", rx_valid3, 1'b1);
        cs_select(3);
        applyStimulus(3, 8'hAA, 4, 1'b1, 8'h99, got);
        checkOutput("t6_busy_mid", busy3, 1'b1);
        checkOutput("t6_tx_full_mid", tx_ready3, 1'b0);
        settled = 1'b0;
        i_rst   = 1'b1;
        wait_cycles(2);
        @(negedge i_clk);
        checkOutput("t6_rst_miso", miso3, 1'b0);
        checkOutput("t6_rst_oe", miso_oe3, 1'b0);
        checkOutput("t6_rst_busy", busy3, 1'b0);
        checkOutput("t6_rst_tx_ready", tx_ready3, 1'b1);
        checkOutput("t6_rst_rx_valid", rx_valid3, 1'b0);
        cs3_n = 1'b1;
        wait_cycles(2);
        i_rst = 1'b0;
        model_reset();
        sclk = 1'b0;
        wait_cycles(6);
        settled = 1'b1;
        checkOutput("t6_post_miso", miso3, 1'b0);
        checkOutput("t6_post_tx_ready", tx_ready3, 1'b1);
        checkOutput("t6_post_rx_valid", rx_valid3, 1'b0);
        wait_cycles(10);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
